// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: default datapath widths, word type and round constants.
package sha256_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_TAG_W = 6;

    typedef logic [31:0] word_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_t1_csa_pipe_csa_row.sv
// One 3:2 carry-save row; the carry word is pre-shifted and its top carry-out dropped.
module csa_row #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = ((a & b) | (c & (a ^ b))) << 1;

endmodule

// File: rtl/sha256_t1_csa_pipe.sv
// Three-stage valid/ready pipeline computing T1 = h + Sigma1 + Ch + K + W (mod 2^WIDTH).
module sha256_t1_csa_pipe
    import sha256_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_h,
    input  logic [WIDTH-1:0] in_sig1,
    input  logic [WIDTH-1:0] in_ch,
    input  logic [WIDTH-1:0] in_k,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_t1,
    output logic [TAG_W-1:0] out_tag
);

    logic             v1, v2;
    logic             rdy1, rdy2, rdy3;
    logic [WIDTH-1:0] s1, c1, k1, w1, s2, c2;
    logic [TAG_W-1:0] tag1, tag2;
    logic [WIDTH-1:0] sa, ca, sb, cb, sc, cc;

    // Ready chain: a stage can load when it is empty or its successor moves.
    assign rdy3     = !out_valid | out_ready;
    assign rdy2     = !v2 | rdy3;
    assign rdy1     = !v1 | rdy2;
    assign in_ready = rst_n & rdy1;

    csa_row #(.WIDTH(WIDTH)) u_row_a (.a(in_h), .b(in_sig1), .c(in_ch), .sum(sa), .carry(ca));
    csa_row #(.WIDTH(WIDTH)) u_row_b (.a(s1),   .b(c1),      .c(k1),    .sum(sb), .carry(cb));
    csa_row #(.WIDTH(WIDTH)) u_row_c (.a(sb),   .b(cb),      .c(w1),    .sum(sc), .carry(cc));

    // S1: first CSA row, carry K and W forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1   <= '0;
            c1   <= '0;
            k1   <= '0;
            w1   <= '0;
            tag1 <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1   <= sa;
                c1   <= ca;
                k1   <= in_k;
                w1   <= in_w;
                tag1 <= in_tag;
            end
        end
    end

    // S2: two chained CSA rows fold in K then W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2   <= '0;
            c2   <= '0;
            tag2 <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s2   <= sc;
                c2   <= cc;
                tag2 <= tag1;
            end
        end
    end

    // S3: final carry-propagate add into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_t1    <= '0;
            out_tag   <= '0;
        end else if (rdy3) begin
            out_valid <= v2;
            if (v2) begin
                out_t1  <= s2 + c2;
                out_tag <= tag2;
            end
        end
    end

endmodule
